// File: rtl/sim_progress_monitor_pkg.sv
// Shared types and default constants for the simulation progress monitor.
package sim_mon_pkg;

    typedef enum logic [1:0] {
        MON_RUN     = 2'd0,
        MON_HALT    = 2'd1,
        MON_HANG    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_e;

    localparam int          DEF_XLEN        = 32;
    localparam int          DEF_CNT_W       = 32;
    localparam logic [31:0] DEF_HALT_ADDR   = 32'h0000_0134;
    localparam int          DEF_HALT_REPEAT = 10;
    localparam int          DEF_HANG_LIMIT  = 1000;
    localparam int          DEF_TIMEOUT     = 5000;
    localparam int          DEF_TRACE_DEPTH = 8;

    // Any state other than RUN means the program has stopped for good.
    function automatic logic mon_is_terminal(input mon_state_e s);
        return s != MON_RUN;
    endfunction

endpackage

// File: rtl/sim_progress_monitor_if.sv
// Bundle of CPU-side observation inputs and monitor result outputs.
interface sim_progress_monitor_if #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8
);
    localparam int CW = $clog2(TRACE_DEPTH + 1);

    logic [XLEN-1:0]  pc_i;
    logic             branch_taken_i;
    logic [XLEN-1:0]  branch_target_i;
    logic             trace_rd_i;
    logic [XLEN-1:0]  trace_data_o;
    logic             trace_valid_o;
    logic [CW-1:0]    trace_count_o;
    logic             trace_ovf_o;
    logic [CNT_W-1:0] instr_count_o;
    logic [CNT_W-1:0] branch_count_o;
    logic [1:0]       state_o;
    logic             done_o;
    logic [XLEN-1:0]  stop_pc_o;

    modport master (
        output pc_i, branch_taken_i, branch_target_i, trace_rd_i,
        input  trace_data_o, trace_valid_o, trace_count_o, trace_ovf_o,
        input  instr_count_o, branch_count_o, state_o, done_o, stop_pc_o
    );

    modport slave (
        input  pc_i, branch_taken_i, branch_target_i, trace_rd_i,
        output trace_data_o, trace_valid_o, trace_count_o, trace_ovf_o,
        output instr_count_o, branch_count_o, state_o, done_o, stop_pc_o
    );

endinterface

// File: rtl/sim_progress_monitor_trace_ring_buffer.sv
// Circular buffer that keeps the most recent DEPTH entries, overwriting the oldest when full.
module trace_ring_buffer #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ovf_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          do_pop;
    logic          full;

    assign do_pop = pop_i && (count_q != '0);
    assign full   = (count_q == CW'(DEPTH));

    // Next-state for storage, pointers, occupancy and the sticky overflow flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (push_i && full && !do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            ovf_d    = 1'b1;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_i && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_i && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Register update; reset also wipes storage so the read port shows zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/sim_progress_monitor.sv
// Run-control monitor: detects halt loop, hung PC and timeout, counts instructions/branches.
module sim_progress_monitor
    import sim_mon_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter int              CNT_W       = DEF_CNT_W,
    parameter logic [XLEN-1:0] HALT_ADDR   = XLEN'(DEF_HALT_ADDR),
    parameter int              HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int              HANG_LIMIT  = DEF_HANG_LIMIT,
    parameter int              TIMEOUT     = DEF_TIMEOUT,
    parameter int              TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input logic                   clk,
    input logic                   rst_n,
    sim_progress_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0] HALT_REP_C = CNT_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] HANG_C     = CNT_W'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] LAST_RUN_C = CNT_W'(TIMEOUT - 1);

    mon_state_e       state_q, state_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             last_vld_q, last_vld_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [XLEN-1:0]  stop_pc_q, stop_pc_d;

    logic in_run;
    logic rep;
    logic at_halt;

    assign in_run  = (state_q == MON_RUN);
    assign rep     = last_vld_q && (mon.pc_i == last_pc_q);
    assign at_halt = (mon.pc_i == HALT_ADDR);

    // FSM next state: halt beats hang beats timeout; the PC is captured on the way out of RUN.
    always_comb begin
        state_d   = state_q;
        stop_pc_d = stop_pc_q;
        if (in_run) begin
            if (rep && at_halt && (run_cnt_q >= HALT_REP_C)) begin
                state_d   = MON_HALT;
                stop_pc_d = mon.pc_i;
            end else if (rep && !at_halt && (run_cnt_q >= HANG_C)) begin
                state_d   = MON_HANG;
                stop_pc_d = mon.pc_i;
            end else if (instr_cnt_q == LAST_RUN_C) begin
                state_d   = MON_TIMEOUT;
                stop_pc_d = mon.pc_i;
            end
        end
    end

    // Repeat tracking and saturating statistics; everything freezes once the run has ended.
    always_comb begin
        last_pc_d    = last_pc_q;
        last_vld_d   = last_vld_q;
        run_cnt_d    = run_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (in_run) begin
            last_pc_d  = mon.pc_i;
            last_vld_d = 1'b1;
            if (rep) begin
                run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
            end else begin
                run_cnt_d = '0;
            end
            instr_cnt_d = (instr_cnt_q == '1) ? instr_cnt_q : instr_cnt_q + 1'b1;
            if (mon.branch_taken_i && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= MON_RUN;
            last_pc_q    <= '0;
            last_vld_q   <= 1'b0;
            run_cnt_q    <= '0;
            instr_cnt_q  <= '0;
            branch_cnt_q <= '0;
            stop_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_pc_q    <= last_pc_d;
            last_vld_q   <= last_vld_d;
            run_cnt_q    <= run_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
            branch_cnt_q <= branch_cnt_d;
            stop_pc_q    <= stop_pc_d;
        end
    end

    trace_ring_buffer #(
        .W     (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (mon.branch_taken_i && in_run),
        .push_data_i (mon.branch_target_i),
        .pop_i       (mon.trace_rd_i),
        .rd_data_o   (mon.trace_data_o),
        .valid_o     (mon.trace_valid_o),
        .count_o     (mon.trace_count_o),
        .ovf_o       (mon.trace_ovf_o)
    );

    assign mon.instr_count_o  = instr_cnt_q;
    assign mon.branch_count_o = branch_cnt_q;
    assign mon.state_o        = state_q;
    assign mon.done_o         = mon_is_terminal(state_q);
    assign mon.stop_pc_o      = stop_pc_q;

endmodule

// File: tb/tb_sim_progress_monitor.sv
// Self-checking bench: two monitor instances with different limits share one stimulus stream.
module tb_sim_progress_monitor;

    localparam int          HANG_A    = 20;
    localparam int          TIMEOUT_A = 5000;
    localparam int          DEPTH_A   = 8;
    localparam int          HANG_B    = 20;
    localparam int          TIMEOUT_B = 50;
    localparam int          DEPTH_B   = 4;
    localparam logic [31:0] HALT_PC   = 32'h134;
    localparam int          HALT_REP  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    sim_progress_monitor_if #(.XLEN(32), .CNT_W(32), .TRACE_DEPTH(DEPTH_A)) ifa ();
    sim_progress_monitor_if #(.XLEN(32), .CNT_W(32), .TRACE_DEPTH(DEPTH_B)) ifb ();

    sim_progress_monitor #(.HANG_LIMIT(HANG_A), .TIMEOUT(TIMEOUT_A), .TRACE_DEPTH(DEPTH_A))
        dut_a (.clk(clk), .rst_n(rst_n), .mon(ifa));
    sim_progress_monitor #(.HANG_LIMIT(HANG_B), .TIMEOUT(TIMEOUT_B), .TRACE_DEPTH(DEPTH_B))
        dut_b (.clk(clk), .rst_n(rst_n), .mon(ifb));

    always #5 clk = ~clk;

    // Reference model, one slot per instance: trace kept as a plain queue of targets.
    int          m_state  [2];
    logic [31:0] m_instr  [2];
    logic [31:0] m_branch [2];
    logic [31:0] m_last_pc[2];
    logic        m_last_vld[2];
    logic [31:0] m_run    [2];
    logic [31:0] m_stop   [2];
    logic        m_ovf    [2];
    logic        m_clean  [2];
    logic [31:0] m_trace  [2][$];
    int          m_hang   [2];
    int          m_timeout[2];
    int          m_depth  [2];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic rst, input logic [31:0] pc,
                              input logic taken, input logic [31:0] tgt, input logic rd);
        logic run;
        logic rep;
        if (!rst) begin
            m_state[k] = 0; m_instr[k] = 0; m_branch[k] = 0; m_last_pc[k] = 0;
            m_last_vld[k] = 0; m_run[k] = 0; m_stop[k] = 0; m_ovf[k] = 0;
            m_clean[k] = 1; m_trace[k].delete();
        end else begin
            run = (m_state[k] == 0);
            if (rd && m_trace[k].size() > 0) void'(m_trace[k].pop_front());
            if (taken && run) begin
                if (m_trace[k].size() == m_depth[k]) begin
                    void'(m_trace[k].pop_front());
                    m_ovf[k] = 1;
                end
                m_trace[k].push_back(tgt);
                m_clean[k] = 0;
            end
            if (run) begin
                rep = m_last_vld[k] && (pc == m_last_pc[k]);
                if (rep && pc == HALT_PC && m_run[k] >= HALT_REP) begin
                    m_state[k] = 1; m_stop[k] = pc;
                end else if (rep && pc != HALT_PC && m_run[k] >= m_hang[k]) begin
                    m_state[k] = 2; m_stop[k] = pc;
                end else if (m_instr[k] == m_timeout[k] - 1) begin
                    m_state[k] = 3; m_stop[k] = pc;
                end
                if (m_instr[k] != 32'hFFFF_FFFF) m_instr[k] = m_instr[k] + 1;
                if (taken && m_branch[k] != 32'hFFFF_FFFF) m_branch[k] = m_branch[k] + 1;
                if (rep) begin
                    if (m_run[k] != 32'hFFFF_FFFF) m_run[k] = m_run[k] + 1;
                end else begin
                    m_run[k] = 0;
                end
                m_last_pc[k] = pc;
                m_last_vld[k] = 1;
            end
        end
    endtask

    task automatic check_one(input int k, input logic [1:0] st, input logic dn,
                             input logic [31:0] ic, input logic [31:0] bc, input logic [31:0] sp,
                             input int cnt, input logic vl, input logic [31:0] dt, input logic ov);
        check_val($sformatf("m%0d.state", k), st, m_state[k]);
        check_val($sformatf("m%0d.done", k), dn, m_state[k] != 0);
        check_val($sformatf("m%0d.instr", k), ic, m_instr[k]);
        check_val($sformatf("m%0d.branch", k), bc, m_branch[k]);
        check_val($sformatf("m%0d.stop_pc", k), sp, m_stop[k]);
        check_val($sformatf("m%0d.tcount", k), cnt, m_trace[k].size());
        check_val($sformatf("m%0d.tvalid", k), vl, m_trace[k].size() > 0);
        check_val($sformatf("m%0d.tovf", k), ov, m_ovf[k]);
        if (m_trace[k].size() > 0)
            check_val($sformatf("m%0d.tdata", k), dt, m_trace[k][0]);
        else if (m_clean[k])
            check_val($sformatf("m%0d.tdata_clr", k), dt, 0);
    endtask

    task automatic checkOutput();
        check_one(0, ifa.state_o, ifa.done_o, ifa.instr_count_o, ifa.branch_count_o, ifa.stop_pc_o,
                  int'(ifa.trace_count_o), ifa.trace_valid_o, ifa.trace_data_o, ifa.trace_ovf_o);
        check_one(1, ifb.state_o, ifb.done_o, ifb.instr_count_o, ifb.branch_count_o, ifb.stop_pc_o,
                  int'(ifb.trace_count_o), ifb.trace_valid_o, ifb.trace_data_o, ifb.trace_ovf_o);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic taken,
                                 input logic [31:0] tgt, input logic rd);
        rst_n = rst;
        ifa.pc_i = pc; ifa.branch_taken_i = taken; ifa.branch_target_i = tgt; ifa.trace_rd_i = rd;
        ifb.pc_i = pc; ifb.branch_taken_i = taken; ifb.branch_target_i = tgt; ifb.trace_rd_i = rd;
        @(posedge clk);
        model_step(0, rst, pc, taken, tgt, rd);
        model_step(1, rst, pc, taken, tgt, rd);
        #1;
        checkOutput();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, ".state"}, ifa.state_o, 0);
        check_val({tag, ".done"}, ifa.done_o, 0);
        check_val({tag, ".instr"}, ifa.instr_count_o, 0);
        check_val({tag, ".branch"}, ifa.branch_count_o, 0);
        check_val({tag, ".stop_pc"}, ifa.stop_pc_o, 0);
        check_val({tag, ".tcount"}, ifa.trace_count_o, 0);
        check_val({tag, ".tvalid"}, ifa.trace_valid_o, 0);
        check_val({tag, ".tdata"}, ifa.trace_data_o, 0);
        check_val({tag, ".tovf"}, ifa.trace_ovf_o, 0);
        check_val({tag, ".b_state"}, ifb.state_o, 0);
    endtask

    task automatic check_timeout_inst(input int cyc);
        if (cyc == TIMEOUT_B - 1) check_val("to.state_before", ifb.state_o, 0);
        if (cyc == TIMEOUT_B) begin
            check_val("to.state", ifb.state_o, 3);
            check_val("to.instr", ifb.instr_count_o, TIMEOUT_B);
        end
        if (cyc == TIMEOUT_B + 10) check_val("to.instr_frozen", ifb.instr_count_o, TIMEOUT_B);
    endtask

    // Ramp 0,4,..,0x130 with a branch every tenth step, then sit in the halt loop.
    task automatic run_halt_sequence(input int pass_no);
        int cyc;
        string tag;
        tag = $sformatf("halt%0d", pass_no);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        cyc = 0;
        for (int i = 0; i < 77; i++) begin
            applyStimulus(1'b1, 32'(4 * i), (i % 10) == 0, 32'h1000 + 32'(i), 1'b0);
            cyc++;
            check_timeout_inst(cyc);
        end
        for (int s = 1; s <= 12; s++) begin
            applyStimulus(1'b1, HALT_PC, 1'b0, 0, 1'b0);
            cyc++;
            check_timeout_inst(cyc);
            if (s == 11) check_val({tag, ".state_s11"}, ifa.state_o, 0);
        end
        check_val({tag, ".state"}, ifa.state_o, 1);
        check_val({tag, ".done"}, ifa.done_o, 1);
        check_val({tag, ".stop_pc"}, ifa.stop_pc_o, HALT_PC);
        check_val({tag, ".instr"}, ifa.instr_count_o, 89);
        check_val({tag, ".branch"}, ifa.branch_count_o, 8);
        check_val({tag, ".tcount"}, ifa.trace_count_o, 8);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, HALT_PC, 1'b1, 32'hDEAD, 1'b0);
        check_val({tag, ".instr_frozen"}, ifa.instr_count_o, 89);
        check_val({tag, ".branch_frozen"}, ifa.branch_count_o, 8);
        check_val({tag, ".tcount_frozen"}, ifa.trace_count_o, 8);
        check_val({tag, ".state_sticky"}, ifa.state_o, 1);
    endtask

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic        rd;
        int          exp_count;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stick;
        logic [31:0] pc;

        m_hang = '{HANG_A, HANG_B};
        m_timeout = '{TIMEOUT_A, TIMEOUT_B};
        m_depth = '{DEPTH_A, DEPTH_B};

        // Ten pushes into the depth-8 ring, drain it, then one pop on empty.
        for (int i = 0; i < 10; i++) begin
            vecs[i].taken = 1'b1; vecs[i].tgt = 32'h10 + 32'(8 * i); vecs[i].rd = 1'b0;
            vecs[i].exp_count = (i < 8) ? i + 1 : 8;
            vecs[i].exp_valid = 1'b1;
            vecs[i].exp_data = (i < 8) ? 32'h10 : 32'h10 + 32'(8 * (i - 7));
            vecs[i].exp_ovf = (i >= 8);
        end
        for (int j = 0; j < 8; j++) begin
            vecs[10 + j].taken = 1'b0; vecs[10 + j].tgt = 0; vecs[10 + j].rd = 1'b1;
            vecs[10 + j].exp_count = 7 - j;
            vecs[10 + j].exp_valid = (j < 7);
            vecs[10 + j].exp_data = 32'h28 + 32'(8 * j);
            vecs[10 + j].exp_ovf = 1'b1;
        end
        vecs[18] = '{1'b0, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b1};
        vecs[19] = '{1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b1};

        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        check_reset_values("reset");

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h2000 + 32'(4 * i), vecs[i].taken, vecs[i].tgt, vecs[i].rd);
            check_val($sformatf("vec%0d.tcount", i), ifa.trace_count_o, vecs[i].exp_count);
            check_val($sformatf("vec%0d.tvalid", i), ifa.trace_valid_o, vecs[i].exp_valid);
            check_val($sformatf("vec%0d.tovf", i), ifa.trace_ovf_o, vecs[i].exp_ovf);
            if (vecs[i].exp_valid)
                check_val($sformatf("vec%0d.tdata", i), ifa.trace_data_o, vecs[i].exp_data);
        end
        check_val("vec.branch_count", ifa.branch_count_o, 10);

        // Push and pop together on a full ring keeps the count and raises no overflow.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 32'h10 + 32'(8 * i), 1'b0);
        applyStimulus(1'b1, 32'h3100, 1'b1, 32'h50, 1'b1);
        check_val("pp_full.tcount", ifa.trace_count_o, 8);
        check_val("pp_full.tovf", ifa.trace_ovf_o, 0);
        check_val("pp_full.tdata", ifa.trace_data_o, 32'h18);

        // Pop on an empty ring changes nothing.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1);
        check_val("pop_empty.tcount", ifa.trace_count_o, 0);
        check_val("pop_empty.tvalid", ifa.trace_valid_o, 0);
        check_val("pop_empty.tovf", ifa.trace_ovf_o, 0);

        // Halt, single-cycle reset, then an identical second run.
        run_halt_sequence(1);
        applyStimulus(1'b0, HALT_PC, 1'b0, 0, 1'b0);
        check_reset_values("halt_reset");
        run_halt_sequence(2);

        // Stuck at 0x80: hang is registered with the 22nd sample.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        for (int s = 1; s <= 22; s++) begin
            applyStimulus(1'b1, 32'h80, 1'b0, 0, 1'b0);
            if (s == 21) check_val("hang.state_s21", ifa.state_o, 0);
        end
        check_val("hang.state", ifa.state_o, 2);
        check_val("hang.done", ifa.done_o, 1);
        check_val("hang.stop_pc", ifa.stop_pc_o, 32'h80);

        // Random traffic with sticky-PC stretches and occasional resets.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
        pc = 0;
        stick = 0;
        for (int n = 0; n < 1500; n++) begin
            if (stick > 0) begin
                stick--;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: pc = pc;
                    4, 5, 6:    pc = pc + 4;
                    7:          begin pc = HALT_PC; stick = $urandom_range(5, 15); end
                    8:          stick = $urandom_range(15, 25);
                    default:    pc = {$urandom_range(0, 255), 2'b00};
                endcase
            end
            applyStimulus(($urandom_range(0, 99) != 0), pc, ($urandom_range(0, 2) == 0),
                          $urandom, ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_progress_monitor.md
# sim_progress_monitor

Parametrised run-control monitor for CPU simulation benches: watches the fetch PC and the EX-stage branch outputs, counts instructions and taken branches, and decides when a program has finished (halt loop), hung (stuck PC elsewhere) or timed out. It keeps a ring buffer of recent branch targets for post-mortem dumps. It sits beside `cpu_top` in every directed bench, so benches no longer hard-code halt addresses and loop thresholds.

## Interface
- `XLEN`, 32, PC/target width
- `CNT_W`, 32, width of instruction and branch counters
- `HALT_ADDR`, 32'h0000_0134, address of the program's terminating self-loop
- `HALT_REPEAT`, 10, repeat cycles at `HALT_ADDR` before declaring halt
- `HANG_LIMIT`, 1000, repeat cycles at any other PC before declaring hang
- `TIMEOUT`, 5000, total RUN cycles before declaring timeout
- `TRACE_DEPTH`, 8, branch-trace entries, power of two, ≥2
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `pc_i`  in  XLEN  current fetch address (`i_mem_addr`)
- `branch_taken_i`  in  1  branch-unit taken strobe
- `branch_target_i`  in  XLEN  branch-unit target
- `trace_rd_i`  in  1  pop oldest trace entry
- `trace_data_o`  out  XLEN  oldest trace entry (first-word fall-through)
- `trace_valid_o`  out  1  trace buffer non-empty
- `trace_count_o`  out  $clog2(TRACE_DEPTH+1)  entries held
- `trace_ovf_o`  out  1  sticky: an entry was overwritten
- `instr_count_o`  out  CNT_W  RUN cycles elapsed
- `branch_count_o`  out  CNT_W  taken branches seen in RUN
- `state_o`  out  2  monitor state
- `done_o`  out  1  state ≠ RUN
- `stop_pc_o`  out  XLEN  PC captured on leaving RUN

## Operation
- States: RUN(0), HALT(1), HANG(2), TIMEOUT(3). HALT/HANG/TIMEOUT are terminal and sticky until reset.
- `last_pc`, `last_vld`, `run_cnt`: each RUN cycle, `last_pc`←`pc_i` and `last_vld`←1. `run_cnt`←`run_cnt`+1 (saturating) if `last_vld` && `pc_i`==`last_pc`, else 0. The first cycle after reset never counts as a repeat.
- Let `rep` = `last_vld` && `pc_i`==`last_pc`.
- RUN→HALT: `rep` && `pc_i`==`HALT_ADDR` && `run_cnt`≥`HALT_REPEAT`.
- RUN→HANG: `rep` && `pc_i`≠`HALT_ADDR` && `run_cnt`≥`HANG_LIMIT`.
- RUN→TIMEOUT: `instr_count`==`TIMEOUT`-1.
- Priority when conditions coincide: HALT > HANG > TIMEOUT.
- `instr_count` increments every RUN cycle. `branch_count` increments on `branch_taken_i` in RUN. Both saturate at all-ones and freeze in terminal states.
- `stop_pc_o` loads `pc_i` in the transition cycle.
- Trace ring:
  - Push `branch_target_i` on `branch_taken_i` in RUN.
  - Pop on `trace_rd_i` when non-empty; pop when empty is ignored.
  - Push when full without pop: overwrite the oldest entry, advance read pointer, count unchanged, set `trace_ovf_o`.
  - Push+pop when full: count unchanged, no overflow.
  - Push+pop when empty: entry is stored, count becomes 1.
  - Pops remain allowed in terminal states; pushes stop.
  - Pointers wrap modulo `TRACE_DEPTH`.

## Timing
- Reset (synchronous, takes effect at the `clk` edge with `rst_n`=0): state RUN; all counters, pointers, `last_pc`, `last_vld`, `stop_pc_o`, `trace_ovf_o` = 0. Outputs `done_o`=0, `trace_valid_o`=0, `trace_count_o`=0, `trace_data_o`=0 (storage cleared).
- Asserting `rst_n`=0 mid-run or in a terminal state returns to RUN on the next edge.
- State, counter and `stop_pc_o` updates are visible one cycle after the qualifying input cycle. `done_o` is combinational from state.
- `trace_data_o`, `trace_valid_o` and `trace_count_o` reflect a push/pop one cycle later. `trace_data_o` is combinational from storage at the read pointer.

## Structure
- `sim_mon_pkg`: 2-bit state typedef/localparams `MON_RUN`, `MON_HALT`, `MON_HANG`, `MON_TIMEOUT`, plus default parameter constants.
- Sub-module `trace_ring_buffer` (params `W`, `DEPTH`): overwrite-on-full circular buffer with push, pop, FWFT data, count and sticky overflow.
- The top holds the FSM, repeat counter and statistics counters.

## Test plan
- `pc_i` steps 0,4,8… then sticks at 0x134: `state_o`=HALT when the 12th consecutive 0x134 sample is registered (sample 11 has `run_cnt`=10), `stop_pc_o`=0x134, and `instr_count_o` freezes.
- `pc_i` sticks at 0x80 with `HANG_LIMIT`=20: HANG one cycle after the 22nd consecutive sample, `done_o`=1.
- `pc_i` increments forever with `TIMEOUT`=50: TIMEOUT after exactly 50 RUN cycles, `instr_count_o`=50.
- 10 taken branches with targets 0x10..0x58 (step 8), `TRACE_DEPTH`=8: `trace_count_o`=8, `trace_ovf_o`=1, pops return 0x20..0x58 in order, then `trace_valid_o`=0; `branch_count_o`=10.
- Push+pop on the same cycle when full: count stays 8 and overflow stays 0. Pop when empty: no change.
- Halt reached, then `rst_n` low for 1 cycle: state RUN, all counters 0, trace empty, and a new run behaves identically.
